spi_bus_bridge: RTL

//  Parametrised successor to the embed-mode SPI loader: an external host drives a bit-serial
//  SPI-like link (sclk/mosi/miso, no chip select) to issue single or auto-incrementing burst

---
 rtl/spi_bus_bridge.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_bus_bridge.sv
// spi_bus_bridge
//   Lets an external host reach the internal bus master port over a bit-serial,
//   SPI-like link (sclk/mosi/miso, no chip select). It is used for program load
//   and debug while the core is held disabled. The host can issue single or
//   auto-incrementing burst reads and writes. The bridge reports bus errors and
//   a bus timeout back to the host.
//
//   Frame from the host, LSB first:
//     start(0), ADDR_W address bits, we, inc, [DATA_W data bits if we]
//   After the bus cycle the host polls miso:
//     busy(1)... done(0), err, [DATA_W read bits], continue
//
// Ports
//   i_clk    in   system clock, all logic on the rising edge
//   i_rst_n  in   asynchronous active-low reset
//   i_sclk   in   host serial clock, asynchronous, idles high
//   i_mosi   in   host data, asynchronous, idles high
//   o_miso   out  status / read data to the host, registered
//   o_req    out  bus request, held until i_ack / i_err / timeout
//   o_we     out  1 = write, 0 = read
//   o_addr   out  bus address
//   o_data   out  write data; holds the last written word
//   i_ack    in   bus completion strobe
//   i_err    in   bus error strobe; takes priority over i_ack
//   i_data   in   read data, valid together with i_ack
//   o_busy   out  high whenever the bridge is not idle
module spi_bus_bridge #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255,
    parameter int SYNC    = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sclk,
    input  logic              i_mosi,
    output logic              o_miso,
    output logic              o_req,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ack,
    input  logic              i_err,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_busy
);

    localparam int MAXW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int BW   = $clog2(MAXW + 1);
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_W - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_CMD0,
        S_CMD1,
        S_WDATA,
        S_BUS,
        S_STAT,
        S_ERRB,
        S_RDATA,
        S_CONT
    } state_t;

    // Synchronisers. They reset to the idle-high level so that leaving reset
    // with the link idle cannot fake a rising edge.
    logic [SYNC-1:0] sclk_sync;
    logic [SYNC-1:0] mosi_sync;
    logic            sclk_prev;
    logic            sclk_rise;
    logic            mosi_bit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_sync <= '1;
            mosi_sync <= '1;
            sclk_prev <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC-2:0], i_sclk};
            mosi_sync <= {mosi_sync[SYNC-2:0], i_mosi};
            sclk_prev <= sclk_sync[SYNC-1];
        end
    end

    assign sclk_rise = sclk_sync[SYNC-1] & ~sclk_prev;
    assign mosi_bit  = mosi_sync[SYNC-1];

    state_t            state_q, state_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              inc_q, inc_d;
    logic              err_q, err_d;
    logic              miso_q, miso_d;
    logic              timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == TCNT_LAST);

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        tcnt_d   = '0;
        addr_d   = addr_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        we_d     = we_q;
        inc_d    = inc_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (sclk_rise && !mosi_bit) begin
                    state_d  = S_ADDR;
                    bitcnt_d = '0;
                end
            end
            S_ADDR: begin
                if (sclk_rise) begin
                    addr_d = {mosi_bit, addr_q[ADDR_W-1:1]};
                    if (bitcnt_q == ADDR_LAST) begin
                        state_d  = S_CMD0;
                        bitcnt_d = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            S_CMD0: begin
                if (sclk_rise) begin
                    we_d    = mosi_bit;
                    state_d = S_CMD1;
                end
            end
            S_CMD1: begin
                if (sclk_rise) begin
                    inc_d    = mosi_bit;
                    state_d  = we_q ? S_WDATA : S_BUS;
                    bitcnt_d = '0;
                end
            end
            S_WDATA: begin
                if (sclk_rise) begin
                    data_d = {mosi_bit, data_q[DATA_W-1:1]};
                    if (bitcnt_q == DATA_LAST) begin
                        state_d  = S_BUS;
                        bitcnt_d = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            S_BUS: begin
                // Host edges are ignored here; the host just polls miso.
                if (i_err) begin
                    err_d   = 1'b1;
                    state_d = S_STAT;
                end else if (i_ack) begin
                    err_d   = 1'b0;
                    rdata_d = i_data;
                    state_d = S_STAT;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_STAT;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_STAT: begin
                if (sclk_rise) state_d = S_ERRB;
            end
            S_ERRB: begin
                if (sclk_rise) begin
                    state_d  = (!we_q && !err_q) ? S_RDATA : S_CONT;
                    bitcnt_d = '0;
                end
            end
            S_RDATA: begin
                // Read data leaves through bit 0 of a shift register.
                if (sclk_rise) begin
                    rdata_d = rdata_q >> 1;
                    if (bitcnt_q == DATA_LAST) begin
                        state_d  = S_CONT;
                        bitcnt_d = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            S_CONT: begin
                if (sclk_rise) begin
                    if (inc_q && !mosi_bit) begin
                        addr_d   = addr_q + 1'b1;
                        state_d  = we_q ? S_WDATA : S_BUS;
                        bitcnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // miso follows the registered state one cycle later.
    always_comb begin
        miso_d = 1'b1;
        case (state_q)
            S_STAT:  miso_d = 1'b0;
            S_ERRB:  miso_d = err_q;
            S_RDATA: miso_d = rdata_q[0];
            default: miso_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            tcnt_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            inc_q    <= 1'b0;
            err_q    <= 1'b0;
            miso_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            tcnt_q   <= tcnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            inc_q    <= inc_d;
            err_q    <= err_d;
            miso_q   <= miso_d;
        end
    end

    assign o_req  = (state_q == S_BUS);
    assign o_busy = (state_q != S_IDLE);
    assign o_we   = we_q;
    assign o_addr = addr_q;
    assign o_data = data_q;
    assign o_miso = miso_q;

endmodule
